// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-bus arbiter.
// Bus widths follow the pipeline's instruction-address and register buses.
package bus_arbiter_pkg;

  localparam int RegBusW      = 32;
  localparam int InstAddrBusW = 32;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_IF   = 2'd1,
    BUS_MEM  = 2'd2
  } bus_state_e;

  // Stall vector bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallIf   = 6'b000111;
  localparam logic [5:0] StallMem  = 6'b011111;

  function automatic logic [5:0] stall_vec(input logic mem_wait, input logic if_wait);
    if (mem_wait) return StallMem;
    if (if_wait)  return StallIf;
    return StallNone;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating busy-cycle counter; o_expired is high while the count sits at TIMEOUT.
// Cleared while the arbiter is idle so each transaction starts counting from zero.
module bus_timeout_cnt
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != Limit)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == Limit);

endmodule

// File: rtl/bus_arbiter.sv
// Serialises IF fetches and MEM load/stores onto one single-port memory bus
// and stalls the pipeline while a requester waits for its transaction.
//
// state    | meaning
// BUS_IDLE | no transaction on the bus; accept MEM first, then IF
// BUS_IF   | instruction fetch in flight, bus outputs held
// BUS_MEM  | load/store in flight, bus outputs held
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = InstAddrBusW,
  parameter int DATA_W  = RegBusW,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  input  logic              flush_i,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic [5:0]        stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  bus_state_e        r_state;
  bus_state_e        w_state_nxt;
  logic              w_start_mem;
  logic              w_start_if;
  logic              w_complete;
  logic              w_expired;
  logic              w_discard;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_mem_wait;
  logic              w_if_wait;
  logic [DATA_W-1:0] w_rdata;

  logic              r_mem_done;
  logic              r_if_done;
  logic              r_discard;
  logic              r_bus_req;
  logic              r_bus_err;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_sel;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_if_inst;
  logic [DATA_W-1:0] r_mem_rdata;

  assign w_cnt_clr = (r_state == BUS_IDLE);
  assign w_cnt_en  = (r_state != BUS_IDLE);

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  assign w_mem_wait = mem_ce_i && !r_mem_done;
  assign w_if_wait  = if_ce_i && !r_if_done;
  // A flush in the completing cycle must also suppress the fetched word.
  assign w_discard  = r_discard || flush_i;
  assign w_rdata    = bus_ack_i ? bus_rdata_i : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_start_mem = 1'b0;
    w_start_if  = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      BUS_IDLE: begin
        if (w_mem_wait) begin
          w_start_mem = 1'b1;
          w_state_nxt = BUS_MEM;
        end else if (w_if_wait) begin
          w_start_if  = 1'b1;
          w_state_nxt = BUS_IF;
        end
      end
      BUS_IF, BUS_MEM: begin
        if (bus_ack_i || w_expired) begin
          w_complete  = 1'b1;
          w_state_nxt = BUS_IDLE;
        end
      end
      default: w_state_nxt = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= BUS_IDLE;
      r_bus_req  <= 1'b0;
      r_mem_done <= 1'b0;
      r_if_done  <= 1'b0;
      r_discard  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_done <= w_complete && (r_state == BUS_MEM);
      r_if_done  <= w_complete && (r_state == BUS_IF) && !w_discard;
      if (w_start_mem || w_start_if) begin
        r_bus_req <= 1'b1;
      end else if (w_complete) begin
        r_bus_req <= 1'b0;
      end
      if (w_complete) begin
        r_discard <= 1'b0;
      end else if ((r_state == BUS_IF) && flush_i) begin
        r_discard <= 1'b1;
      end
      if (w_complete && !bus_ack_i) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= 4'h0;
      r_bus_wdata <= '0;
    end else if (w_start_mem) begin
      r_bus_we    <= mem_we_i;
      r_bus_addr  <= mem_addr_i;
      r_bus_sel   <= mem_sel_i;
      r_bus_wdata <= mem_wdata_i;
    end else if (w_start_if) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= if_addr_i;
      r_bus_sel   <= 4'hF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_inst   <= '0;
      r_mem_rdata <= '0;
    end else if (w_complete) begin
      if (r_state == BUS_MEM) begin
        r_mem_rdata <= w_rdata;
      end else if (!w_discard) begin
        r_if_inst <= w_rdata;
      end
    end
  end

  assign stall_o     = stall_vec(w_mem_wait, w_if_wait);
  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_sel_o   = r_bus_sel;
  assign bus_wdata_o = r_bus_wdata;
  assign bus_err_o   = r_bus_err;
  assign if_inst_o   = r_if_inst;
  assign mem_rdata_o = r_mem_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a transaction-level reference model
// compared on every falling edge, plus literal expectations per scenario.
module tb_bus_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce = 1'b0;
  logic [31:0] if_addr = '0;
  logic        flush = 1'b0;
  logic        mem_ce = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  logic [31:0] if_inst_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic [5:0]  stall_o;
  logic        bus_req_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;

  int total = 0;
  int bad = 0;
  int ack_delay = 0;
  int busy_cnt = 0;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_inst_o(if_inst_o), .flush_i(flush),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_sel_i(mem_sel),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata_o), .stall_o(stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_for(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h3401_0020;
      32'h0000_1004: return 32'h1111_2222;
      32'h0000_2000: return 32'hCAFE_F00D;
      32'h0000_0044: return 32'h0BAD_C0DE;
      32'h0000_5000: return 32'h7777_8888;
      32'h0000_5004: return 32'h9999_0000;
      32'h0000_6000: return 32'hABCD_0123;
      default:       return ~a;
    endcase
  endfunction

  // Memory responder: acks after ack_delay busy cycles (negative = never)
  always @(posedge clk) begin
    #1;
    if (bus_req_o) begin
      if (busy_cnt == ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = rd_for(bus_addr_o);
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'hEEEE_EEEE;
      end
      busy_cnt++;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = 32'hEEEE_EEEE;
      busy_cnt  = 0;
    end
  end

  // Reference model: owner 0 none, 1 IF, 2 MEM; age = busy cycles elapsed
  int          m_owner, m_age;
  bit          m_mdone, m_idone, m_disc, m_err, m_mrd_known;
  logic [31:0] m_inst, m_mrd, m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_sel;

  always @(posedge clk or negedge rst) begin
    bit nm, ni, fin;
    logic [31:0] d;
    if (!rst) begin
      m_owner = 0; m_age = 0; m_mdone = 0; m_idone = 0; m_disc = 0; m_err = 0;
      m_inst = '0; m_mrd = '0; m_mrd_known = 1; m_addr = '0; m_wdata = '0;
      m_we = 0; m_sel = '0;
    end else begin
      nm = 0;
      ni = 0;
      if (m_owner == 0) begin
        if (mem_ce && !m_mdone) begin
          m_owner = 2; m_age = 0;
          m_addr = mem_addr; m_we = mem_we; m_sel = mem_sel; m_wdata = mem_wdata;
        end else if (if_ce && !m_idone) begin
          m_owner = 1; m_age = 0;
          m_addr = if_addr; m_we = 0; m_sel = 4'hF;
        end
      end else begin
        fin = bus_ack || (m_age == TMO);
        if (fin) begin
          d = bus_ack ? bus_rdata : 32'h0;
          if (!bus_ack) m_err = 1;
          if (m_owner == 2) begin
            m_mrd = d; m_mrd_known = !m_we; nm = 1;
          end else if (!(m_disc || flush)) begin
            m_inst = d; ni = 1;
          end
          m_disc = 0;
          m_owner = 0;
        end else begin
          if (m_owner == 1 && flush) m_disc = 1;
          m_age++;
        end
      end
      m_mdone = nm;
      m_idone = ni;
    end
  end

  always @(negedge clk) begin
    logic [5:0] es;
    if (rst) begin
      es = (mem_ce && !m_mdone) ? 6'b011111 : (if_ce && !m_idone) ? 6'b000111 : 6'b000000;
      chk("m_req", bus_req_o, m_owner != 0);
      chk("m_stall", stall_o, es);
      chk("m_if_inst", if_inst_o, m_inst);
      chk("m_err", bus_err_o, m_err);
      if (m_mrd_known) chk("m_mem_rdata", mem_rdata_o, m_mrd);
      if (m_owner != 0) begin
        chk("m_addr", bus_addr_o, m_addr);
        chk("m_we", bus_we_o, m_we);
        chk("m_sel", bus_sel_o, m_sel);
        if (m_owner == 2) chk("m_wdata", bus_wdata_o, m_wdata);
      end
    end
  end

  // One request on one port; counts bus_req and stall cycles until stall releases
  task automatic txn(input bit is_mem, input bit we, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] wd, input int dly,
                     output int n_req, output int n_stall);
    bit done = 0;
    n_req = 0;
    n_stall = 0;
    ack_delay = dly;
    if (is_mem) begin
      mem_ce = 1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wd;
    end else begin
      if_ce = 1; if_addr = addr;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_req_o) n_req++;
      if (stall_o != 6'b0) n_stall++;
      else begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) chk("txn_bound", 0, 1);
    tick();
    mem_ce = 0; mem_we = 0; if_ce = 0;
  endtask

  initial begin
    int nr, ns;
    bit saw_bad, done;

    #3;
    chk("rst_req", bus_req_o, 0);
    chk("rst_inst", if_inst_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_err", bus_err_o, 0);
    @(negedge clk); #2 rst = 1;
    tick();

    // IF only, immediate ack
    txn(0, 0, 32'h1000, 4'h0, 32'h0, 0, nr, ns);
    chk("if1_nreq", nr, 1);
    chk("if1_nstall", ns, 2);
    chk("if1_inst", if_inst_o, 32'h3401_0020);

    // MEM write and IF together: MEM first, IF after one idle cycle
    mem_ce = 1; mem_we = 1; mem_addr = 32'h100; mem_sel = 4'b0011; mem_wdata = 32'hDEAD_BEEF;
    if_ce = 1; if_addr = 32'h1004; ack_delay = 0;
    @(negedge clk); chk("both_c0_stall", stall_o, 6'b011111);
    tick(); @(negedge clk);
    chk("both_c1_req", bus_req_o, 1);
    chk("both_c1_addr", bus_addr_o, 32'h100);
    chk("both_c1_we", bus_we_o, 1);
    chk("both_c1_sel", bus_sel_o, 4'b0011);
    chk("both_c1_stall", stall_o, 6'b011111);
    tick(); @(negedge clk);
    chk("both_c2_req", bus_req_o, 0);
    chk("both_c2_stall", stall_o, 6'b000111);
    tick(); mem_ce = 0; mem_we = 0; @(negedge clk);
    chk("both_c3_req", bus_req_o, 1);
    chk("both_c3_addr", bus_addr_o, 32'h1004);
    chk("both_c3_we", bus_we_o, 0);
    chk("both_c3_sel", bus_sel_o, 4'hF);
    tick(); @(negedge clk);
    chk("both_c4_inst", if_inst_o, 32'h1111_2222);
    chk("both_c4_req", bus_req_o, 0);
    chk("both_c4_stall", stall_o, 6'b0);
    tick(); if_ce = 0;

    // Slow MEM read, ack after 5 waiting cycles
    txn(1, 0, 32'h2000, 4'b1100, 32'h55AA_55AA, 5, nr, ns);
    chk("slow_nreq", nr, 6);
    chk("slow_nstall", ns, 7);
    chk("slow_rdata", mem_rdata_o, 32'hCAFE_F00D);

    // Flush during IF_BUSY: result dropped, redirected fetch follows
    txn(0, 0, 32'h5000, 4'h0, 32'h0, 0, nr, ns);
    chk("fl_pre_inst", if_inst_o, 32'h7777_8888);
    if_ce = 1; if_addr = 32'h5004; ack_delay = 3;
    saw_bad = 0;
    done = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 2) begin flush = 1; if_addr = 32'h6000; end
      if (k == 3) flush = 0;
      @(negedge clk);
      if (if_inst_o == 32'h9999_0000) saw_bad = 1;
      if (k == 5) chk("fl_c5_inst", if_inst_o, 32'h7777_8888);
      if (stall_o == 6'b0) begin done = 1; break; end
      tick();
    end
    chk("fl_done", done, 1);
    chk("fl_discarded", saw_bad, 0);
    chk("fl_new_inst", if_inst_o, 32'hABCD_0123);
    tick(); if_ce = 0;

    // Timeout: no ack, terminates after TMO counted cycles with zero data
    txn(0, 0, 32'h3000, 4'h0, 32'h0, -1, nr, ns);
    chk("to_nreq", nr, TMO + 1);
    chk("to_nstall", ns, TMO + 2);
    chk("to_inst", if_inst_o, 0);
    chk("to_err", bus_err_o, 1);
    txn(1, 0, 32'h44, 4'hF, 32'h0, 0, nr, ns);
    chk("to_good_rdata", mem_rdata_o, 32'h0BAD_C0DE);
    chk("to_err_sticky", bus_err_o, 1);

    // Asynchronous reset in the middle of MEM_BUSY
    mem_ce = 1; mem_we = 1; mem_addr = 32'h7000; mem_sel = 4'hF; mem_wdata = 32'h1234_5678;
    ack_delay = -1;
    tick(); tick();
    chk("ar_busy_req", bus_req_o, 1);
    #2 rst = 0;
    #1;
    chk("ar_req", bus_req_o, 0);
    chk("ar_err", bus_err_o, 0);
    chk("ar_addr", bus_addr_o, 0);
    chk("ar_we", bus_we_o, 0);
    chk("ar_sel", bus_sel_o, 0);
    chk("ar_wdata", bus_wdata_o, 0);
    chk("ar_inst", if_inst_o, 0);
    chk("ar_rdata", mem_rdata_o, 0);
    chk("ar_stall", stall_o, 6'b011111);
    mem_ce = 0; mem_we = 0;
    @(negedge clk); #2 rst = 1;
    tick();
    txn(0, 0, 32'h1000, 4'h0, 32'h0, 0, nr, ns);
    chk("ar_after_nreq", nr, 1);
    chk("ar_after_inst", if_inst_o, 32'h3401_0020);
    chk("ar_after_err", bus_err_o, 0);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
